// File: rtl/line_buffer_7x7_if.sv
// Pixel input stream for line_buffer_7x7: one 8-bit pixel per valid/ready handshake.
interface line_buffer_7x7_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;

    modport master (output data_i, output valid_i, input  ready_o);
    modport slave  (input  data_i, input  valid_i, output ready_o);
endinterface

// File: rtl/line_buffer_7x7.sv
// line_buffer_7x7: raster-order line buffer and 7-tap column sequencer for a 7x7 window stage.
// Keeps six previous rows, emits one vertical column per shift and inserts the
// horizontal (3 columns per row) and vertical (3 rows per frame) zero flush shifts.
// Optional feature: define LINE_BUFFER_7X7_STALL_EN to add the stall_i input.
//
// state  | meaning
// IDLE   | waiting for the first pixel of a frame, ready_o=1
// RUN    | accepting image pixels, one shift per accept
// HFLUSH | col in COLS..COLS+2, zero column shifted every cycle, ready_o=0
// VFLUSH | row in ROWS..ROWS+2, zero pixel shifted every cycle for col < COLS
module line_buffer_7x7 #(
    parameter int ROWS = 7,
    parameter int COLS = 7
) (
    input  logic       clk,
    input  logic       rst,
`ifdef LINE_BUFFER_7X7_STALL_EN
    input  logic       stall_i,
`endif
    line_buffer_7x7_if.slave pix_if,
    output logic [7:0] d1_o,
    output logic [7:0] d2_o,
    output logic [7:0] d3_o,
    output logic [7:0] d4_o,
    output logic [7:0] d5_o,
    output logic [7:0] d6_o,
    output logic [7:0] d7_o,
    output logic       start_o,
    output logic       done_o,
    output logic       frame_done_o
);

    localparam int COL_W = $clog2(COLS + 3);
    localparam int ROW_W = $clog2(ROWS + 3);
    localparam int AW    = $clog2(COLS);

    localparam logic [COL_W-1:0] COLS_C   = COL_W'(COLS);
    localparam logic [COL_W-1:0] COL_EDGE = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS + 2);
    localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS + 2);
    localparam logic [COL_W-1:0] COL_CTR  = COL_W'(3);
    localparam logic [ROW_W-1:0] ROW_CTR  = ROW_W'(3);

    typedef enum logic [1:0] {IDLE, RUN, HFLUSH, VFLUSH} state_t;

    state_t           state_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic             ready_q;
    logic [7:0]       tap_q [7];
    logic [7:0]       tap_d [7];
    logic             start_q;
    logic             done_p_q;
    logic             done_q;
    logic             fd_p_q;
    logic             fd_q;

    // line_mem[0] is the previous row, line_mem[5] the row six lines back
    logic [7:0]       line_mem [6][COLS];

    logic             stall;
    logic             accept;
    logic             flushing;
    logic             shift;
    logic             in_img;
    logic [AW-1:0]    col_a;
    logic [7:0]       pixel;

`ifdef LINE_BUFFER_7X7_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    assign pix_if.ready_o = ready_q & ~stall;
    assign accept   = pix_if.valid_i & pix_if.ready_o;
    assign flushing = (state_q == HFLUSH) || (state_q == VFLUSH);
    assign shift    = flushing ? ~stall : accept;
    assign in_img   = col_q < COLS_C;
    assign col_a    = col_q[AW-1:0];
    assign pixel    = (state_q == VFLUSH) ? 8'd0 : pix_if.data_i;

    // Column taps read before the cascade write; zero outside the image width
    always_comb begin
        for (int k = 0; k < 7; k++) tap_d[k] = 8'd0;
        if (in_img) begin
            tap_d[0] = pixel;
            for (int k = 1; k < 7; k++) tap_d[k] = line_mem[k-1][col_a];
        end
    end

    // Row cascade: each shift inside the image pushes the column one line deeper
    always_ff @(posedge clk) begin
        if (shift && in_img) begin
            line_mem[0][col_a] <= pixel;
            for (int k = 1; k < 6; k++) line_mem[k][col_a] <= line_mem[k-1][col_a];
        end
    end

    // Sequencer FSM with shift counters and registered strobes/taps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            ready_q  <= 1'b1;
            start_q  <= 1'b0;
            done_p_q <= 1'b0;
            done_q   <= 1'b0;
            fd_p_q   <= 1'b0;
            fd_q     <= 1'b0;
            for (int k = 0; k < 7; k++) tap_q[k] <= 8'd0;
        end else begin
            start_q  <= shift;
            done_p_q <= shift && (row_q >= ROW_CTR) && (col_q >= COL_CTR);
            fd_p_q   <= shift && (row_q == ROW_LAST) && (col_q == COL_LAST);
            done_q   <= done_p_q;
            fd_q     <= fd_p_q;
            if (shift) begin
                for (int k = 0; k < 7; k++) tap_q[k] <= tap_d[k];
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    if (row_q == ROW_LAST) begin
                        row_q   <= '0;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else if (row_q < ROW_EDGE) begin
                        row_q   <= row_q + 1'b1;
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        row_q   <= row_q + 1'b1;
                        state_q <= VFLUSH;
                        ready_q <= 1'b0;
                    end
                end else begin
                    col_q <= col_q + 1'b1;
                    if (col_q == COL_EDGE) begin
                        state_q <= HFLUSH;
                        ready_q <= 1'b0;
                    end else if (state_q == IDLE) begin
                        state_q <= RUN;
                    end
                end
            end
        end
    end

    assign d1_o         = tap_q[0];
    assign d2_o         = tap_q[1];
    assign d3_o         = tap_q[2];
    assign d4_o         = tap_q[3];
    assign d5_o         = tap_q[4];
    assign d6_o         = tap_q[5];
    assign d7_o         = tap_q[6];
    assign start_o      = start_q;
    assign done_o       = done_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_line_buffer_7x7.sv
// Scoreboard bench for line_buffer_7x7 with ROWS=COLS=7 and pixel p(r,c)=7r+c+1.
module tb_line_buffer_7x7;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef LINE_BUFFER_7X7_STALL_EN
    logic stall = 1'b0;
`endif
    always #5 clk = ~clk;

    line_buffer_7x7_if pif ();
    logic [7:0] d1, d2, d3, d4, d5, d6, d7;
    logic       start, done, fdone;

    line_buffer_7x7 #(.ROWS(7), .COLS(7)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef LINE_BUFFER_7X7_STALL_EN
        .stall_i      (stall),
`endif
        .pix_if       (pif),
        .d1_o         (d1),
        .d2_o         (d2),
        .d3_o         (d3),
        .d4_o         (d4),
        .d5_o         (d5),
        .d6_o         (d6),
        .d7_o         (d7),
        .start_o      (start),
        .done_o       (done),
        .frame_done_o (fdone)
    );

    typedef struct packed {
        logic [55:0] taps;
        logic [55:0] mask;
        logic        done;
        logic        fd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic pend_done = 1'b0;
    logic pend_fd   = 1'b0;
    int   f_starts, f_dones, f_fds;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int r, input int c);
        return (r < 7 && c < 7) ? 8'(7 * r + c + 1) : 8'd0;
    endfunction

    // One record per shift of a frame: taps of column c with rows r..r-6
    task automatic push_frame();
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                exp_t e;
                e = '0;
                for (int k = 0; k < 7; k++) begin
                    int src;
                    src = r - k;
                    if (c >= 7) begin
                        e.mask[8*k +: 8] = 8'hFF;
                    end else if (src >= 0) begin
                        e.taps[8*k +: 8] = pix(src, c);
                        e.mask[8*k +: 8] = 8'hFF;
                    end
                end
                e.done = (r >= 3) && (c >= 3);
                e.fd   = (r == 9) && (c == 9);
                sb.push_back(e);
            end
        end
    endtask

    // Output monitor: every start_o pops one record, done_o must follow one cycle later
    always @(negedge clk) begin
        if (!rst) begin
            pend_done = 1'b0;
            pend_fd   = 1'b0;
        end else begin
            check_val("done", done, pend_done);
            check_val("frame_done", fdone, pend_fd);
            if (done) f_dones++;
            if (fdone) begin
                f_fds++;
                check_val("fd_with_49th_done", f_dones, 49);
            end
            pend_done = 1'b0;
            pend_fd   = 1'b0;
            if (start) begin
                f_starts++;
                check_val("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check_val("taps", {d7, d6, d5, d4, d3, d2, d1} & mon_e.mask,
                              mon_e.taps & mon_e.mask);
                    pend_done = mon_e.done;
                    pend_fd   = mon_e.fd;
                end
            end
        end
    end

    // mode 0: continuous valid, 1: valid toggling, 2: continuous with mid-row stall
    task automatic send_frame(input int mode, input int stop_at);
        int idx, gap, cyc, budget;
        bit did_stall;
        idx = 0; gap = 0; cyc = 0; budget = 0; did_stall = 0;
        while (idx < 49 && idx != stop_at && budget < 2000) begin
            @(negedge clk);
            budget++;
            cyc++;
`ifdef LINE_BUFFER_7X7_STALL_EN
            if (mode == 2 && idx == 24 && !did_stall) begin
                did_stall = 1;
                for (int s = 0; s < 5; s++) begin
                    if (s > 0) @(negedge clk);
                    stall = 1'b1;
                    pif.valid_i = 1'b1;
                    pif.data_i  = pix(idx / 7, idx % 7);
                    #1;
                    check_val("stall_ready", pif.ready_o, 0);
                    if (s > 0) check_val("stall_start", start, 0);
                    if (s > 1) check_val("stall_done", done, 0);
                end
                @(negedge clk);
                stall = 1'b0;
                check_val("stall_start_end", start, 0);
                check_val("stall_done_end", done, 0);
            end
`endif
            pif.valid_i = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            pif.data_i  = pix(idx / 7, idx % 7);
            #1;
            if (pif.valid_i && pif.ready_o) begin
                if (mode == 0) check_val("ready_gap", gap, (idx > 0 && idx % 7 == 0) ? 3 : 0);
                gap = 0;
                idx++;
            end else if (pif.valid_i) begin
                gap++;
            end
        end
        check_val("send_budget", budget < 2000, 1);
        @(negedge clk);
        pif.valid_i = 1'b0;
    endtask

    task automatic run_frame(input int mode);
        int w;
        f_starts = 0; f_dones = 0; f_fds = 0;
        push_frame();
        send_frame(mode, -1);
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check_val("drain", sb.size(), 0);
        check_val("starts", f_starts, 100);
        check_val("dones", f_dones, 49);
        check_val("frame_dones", f_fds, 1);
        check_val("ready_idle", pif.ready_o, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        pif.valid_i = 1'b0;
        pif.data_i  = 8'd0;
        f_starts = 0; f_dones = 0; f_fds = 0;
        repeat (3) @(negedge clk);
        check_val("rst_taps", {d7, d6, d5, d4, d3, d2, d1}, 0);
        check_val("rst_start", start, 0);
        check_val("rst_done", done, 0);
        check_val("rst_fd", fdone, 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("ready_after_rst", pif.ready_o, 1);

        run_frame(0);
        run_frame(1);

        // reset in the middle of a frame, then a clean frame
        push_frame();
        send_frame(0, 20);
        rst = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        check_val("midrst_taps", {d7, d6, d5, d4, d3, d2, d1}, 0);
        check_val("midrst_start", start, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_fd", fdone, 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_ready", pif.ready_o, 1);
        run_frame(0);

`ifdef LINE_BUFFER_7X7_STALL_EN
        run_frame(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
